// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_sign_mask,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_sign_mask,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    output logic        grant
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             win_c;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // On a tie the port that did not win last time goes first.
    always_comb win_c = (p0_req && p1_req) ? ~last_grant : ~p0_req;
`else
    always_comb win_c = ~p0_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            grant          <= 1'b0;
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        // Strobes are registered so they are high exactly during ISSUE.
                        grant          <= win_c;
                        we_q           <= win_c ? p1_we : p0_we;
                        mem_addr       <= win_c ? p1_addr : p0_addr;
                        mem_write_data <= win_c ? p1_wdata : p0_wdata;
                        mem_sign_mask  <= win_c ? p1_sign_mask : p0_sign_mask;
                        mem_memread    <= win_c ? ~p1_we : ~p0_we;
                        mem_memwrite   <= win_c ? p1_we : p0_we;
`ifdef DMEM_ARB_RR_EN
                        last_grant     <= win_c;
`endif
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_W'(MEM_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (!we_q) begin
                            if (grant) p1_rdata <= mem_read_data;
                            else       p0_rdata <= mem_read_data;
                        end
                        p0_ack <= ~grant;
                        p1_ack <= grant;
                        state  <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default latency plus a MEM_LAT=5 instance).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_sign_mask, p1_sign_mask;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, grant;

    logic        p0_req5;
    logic        p1_req5;
    logic        p0_ack5, p1_ack5;
    logic [31:0] p0_rdata5, p1_rdata5;
    logic [31:0] mem_addr5, mem_write_data5, mem_read_data5;
    logic [3:0]  mem_sign_mask5;
    logic        mem_memread5, mem_memwrite5, grant5;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .grant(grant)
    );

    dmem_arbiter #(.MEM_LAT(5)) dut5 (
        .clk(clk), .rst(rst),
        .p0_req(p0_req5), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack5), .p0_rdata(p0_rdata5),
        .p1_req(p1_req5), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack5), .p1_rdata(p1_rdata5),
        .mem_addr(mem_addr5), .mem_write_data(mem_write_data5), .mem_sign_mask(mem_sign_mask5),
        .mem_memread(mem_memread5), .mem_memwrite(mem_memwrite5),
        .mem_read_data(mem_read_data5), .grant(grant5)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_sign_mask = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_sign_mask = '0;
        p0_req5 = 0; p1_req5 = 0;
        mem_read_data = '0; mem_read_data5 = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_vec++; if ({p0_ack, p1_ack, mem_memread, mem_memwrite, grant} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {p0_ack, p1_ack, mem_memread, mem_memwrite, grant}); end
        n_vec++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_vec++; if (mem_write_data !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_write_data); end
        n_vec++; if (mem_sign_mask !== 4'h0) begin n_bad++; $display("FAIL reset_mask: got %h want 0", mem_sign_mask); end
        n_vec++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata); end
        rst = 1'b0;
        next_cycle();
    endtask

    // p0 load of 0xDEADBEEF; memory data valid only in cycle 3.
    task automatic test_p0_load();
        p0_req = 1; p0_we = 0; p0_addr = 32'h1004; p0_sign_mask = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            mem_read_data = (c == 3) ? 32'hDEADBEEF : 32'hBAD0BAD0;
            @(negedge clk);
            n_vec++; if ({mem_memread, mem_memwrite} !== {c == 1, 1'b0}) begin
                n_bad++; $display("FAIL load_strobe c%0d: got %b want %b", c, {mem_memread, mem_memwrite}, {c == 1, 1'b0}); end
            n_vec++; if ({p0_ack, p1_ack} !== {c == 4, 1'b0}) begin
                n_bad++; $display("FAIL load_ack c%0d: got %b want %b", c, {p0_ack, p1_ack}, {c == 4, 1'b0}); end
            if (c == 1 || c == 4) begin
                n_vec++; if (mem_addr !== 32'h1004 || mem_sign_mask !== 4'b0010) begin
                    n_bad++; $display("FAIL load_addr c%0d: got %h/%b want 00001004/0010", c, mem_addr, mem_sign_mask); end
            end
            if (c == 4) begin
                n_vec++; if (p0_rdata !== 32'hDEADBEEF) begin
                    n_bad++; $display("FAIL load_rdata: got %h want deadbeef", p0_rdata); end
            end
            next_cycle();
            if (c == 4) p0_req = 0;
        end
    endtask

    // p1 byte store; rdata of both ports must not move.
    task automatic test_p1_store();
        p1_req = 1; p1_we = 1; p1_addr = 32'h1008; p1_wdata = 32'h000000A5; p1_sign_mask = 4'b0001;
        mem_read_data = 32'hBAD0BAD0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++; if ({mem_memread, mem_memwrite} !== {1'b0, c == 1}) begin
                n_bad++; $display("FAIL store_strobe c%0d: got %b want %b", c, {mem_memread, mem_memwrite}, {1'b0, c == 1}); end
            n_vec++; if ({p0_ack, p1_ack} !== {1'b0, c == 4}) begin
                n_bad++; $display("FAIL store_ack c%0d: got %b want %b", c, {p0_ack, p1_ack}, {1'b0, c == 4}); end
            if (c == 1) begin
                n_vec++; if (mem_addr !== 32'h1008 || mem_write_data !== 32'hA5 || mem_sign_mask !== 4'b0001) begin
                    n_bad++; $display("FAIL store_bus: got %h/%h/%b want 00001008/000000a5/0001", mem_addr, mem_write_data, mem_sign_mask); end
                n_vec++; if (grant !== 1'b1) begin n_bad++; $display("FAIL store_grant: got %b want 1", grant); end
            end
            if (c == 4) begin
                n_vec++; if (p1_rdata !== 32'h0 || p0_rdata !== 32'hDEADBEEF) begin
                    n_bad++; $display("FAIL store_rdata: got %h/%h want deadbeef/00000000", p0_rdata, p1_rdata); end
            end
            next_cycle();
            if (c == 4) p1_req = 0;
        end
    endtask

    // MEM_LAT=5 instance: data valid only in cycle 6, ack in cycle 7.
    task automatic test_lat5();
        p0_req5 = 1; p0_we = 0; p0_addr = 32'h1010; p0_sign_mask = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            mem_read_data5 = (c == 6) ? 32'h12345678 : 32'hBAD0BAD0;
            @(negedge clk);
            n_vec++; if (mem_memread5 !== (c == 1)) begin
                n_bad++; $display("FAIL lat5_strobe c%0d: got %b want %b", c, mem_memread5, c == 1); end
            n_vec++; if ({p0_ack5, p1_ack5} !== {c == 7, 1'b0}) begin
                n_bad++; $display("FAIL lat5_ack c%0d: got %b want %b", c, {p0_ack5, p1_ack5}, {c == 7, 1'b0}); end
            if (c == 7) begin
                n_vec++; if (p0_rdata5 !== 32'h12345678) begin
                    n_bad++; $display("FAIL lat5_rdata: got %h want 12345678", p0_rdata5); end
            end
            next_cycle();
            if (c == 7) p0_req5 = 0;
        end
    endtask

    // Both ports request continuously; four completions expected 5 cycles apart.
    task automatic test_back_to_back();
        int  ack_cyc[4];
        int  n = 0;
        logic exp_g;
        p0_we = 0; p0_addr = 32'h3000; p1_we = 0; p1_addr = 32'h3100;
        mem_read_data = 32'h11110000;
        p0_req = 1; p1_req = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
`ifdef DMEM_ARB_RR_EN
                exp_g = n[0];
`else
                exp_g = 1'b0;
`endif
                ack_cyc[n] = c;
                n_vec++; if (grant !== exp_g) begin
                    n_bad++; $display("FAIL b2b_grant #%0d: got %b want %b", n, grant, exp_g); end
                n_vec++; if ({p0_ack, p1_ack} !== {~exp_g, exp_g}) begin
                    n_bad++; $display("FAIL b2b_ack #%0d: got %b want %b", n, {p0_ack, p1_ack}, {~exp_g, exp_g}); end
                n_vec++; if (ack_cyc[n] !== 4 + 5 * n) begin
                    n_bad++; $display("FAIL b2b_cycle #%0d: got %0d want %0d", n, ack_cyc[n], 4 + 5 * n); end
                n++;
            end
            next_cycle();
        end
        p0_req = 0; p1_req = 0;
        n_vec++; if (n !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d acks want 4", n); end
        repeat (2) next_cycle();
    endtask

    // Reset during WAIT aborts the load with no ack; a fresh load then completes.
    task automatic test_mid_reset();
        p0_req = 1; p0_we = 0; p0_addr = 32'h2000; p0_sign_mask = 4'b0000;
        mem_read_data = 32'h55555555;
        for (int c = 0; c < 13; c++) begin
            if (c == 2) rst = 1;
            if (c == 3) begin rst = 0; p0_req = 0; end
            @(negedge clk);
            if (c >= 3) begin
                n_vec++; if ({mem_memread, mem_memwrite, p0_ack, p1_ack} !== 4'b0) begin
                    n_bad++; $display("FAIL abort_quiet c%0d: got %b want 0000", c, {mem_memread, mem_memwrite, p0_ack, p1_ack}); end
            end
            if (c == 3) begin
                n_vec++; if (grant !== 1'b0 || p0_rdata !== 32'h0 || mem_addr !== 32'h0) begin
                    n_bad++; $display("FAIL abort_state: got %b/%h/%h want 0/0/0", grant, p0_rdata, mem_addr); end
            end
            next_cycle();
        end
        test_p0_load();
    endtask

    initial begin
        test_reset();
        test_p0_load();
        test_p1_store();
        test_lat5();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. Accepts word/halfword/byte load and store requests from port 0 (core load/store unit) and port 1 (debug/DMA master) and serialises them onto the memory's one-cycle read/write strobe interface. It waits a fixed memory latency, then returns the read data and a one-cycle acknowledge to the winning port. Sits between the core/debug masters and the data memory; the memory's LED and address-decode behaviour pass through unchanged.

## Interface
- MEM_LAT, 2, cycles from the end of the strobe cycle until memory read data is valid; legal range 1..15.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- p0_req / p1_req  input  1  request; held high until that port's ack.
- p0_we / p1_we  input  1  1 = store, 0 = load; stable while req.
- p0_addr / p1_addr  input  32  byte address; stable while req.
- p0_wdata / p1_wdata  input  32  store data; stable while req.
- p0_sign_mask / p1_sign_mask  input  4  access size/sign code, passed to memory unchanged.
- p0_ack / p1_ack  output  1  one-cycle completion pulse.
- p0_rdata / p1_rdata  output  32  load result; valid in the ack cycle, held until that port's next load completes.
- mem_addr  output  32  to memory addr.
- mem_write_data  output  32  to memory write_data.
- mem_sign_mask  output  4  to memory sign_mask.
- mem_memread / mem_memwrite  output  1  one-cycle strobes.
- mem_read_data  input  32  from memory read_data.
- grant  output  1  port owning the current transaction (0/1); meaningful outside IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req high, choose winner, latch its we/addr/wdata/sign_mask and grant, go to ISSUE; else stay.
- ISSUE (exactly 1 cycle): mem_memread = !we_latched, mem_memwrite = we_latched; load counter with MEM_LAT; go to WAIT.
- WAIT (exactly MEM_LAT cycles): counter decrements; on the edge ending the last WAIT cycle, for a load, capture mem_read_data into the granted port's rdata register; go to RESP.
- RESP (1 cycle): granted port's ack = 1; go to IDLE.
- mem_memread/mem_memwrite are 0 in every state except ISSUE; never both 1.
- mem_addr/mem_write_data/mem_sign_mask driven from the latched registers; they hold their value outside ISSUE.
- Stores never modify rdata. The non-granted port's ack stays 0 and its rdata holds.
- Arbitration with fixed priority (macro absent): port 0 wins any simultaneous request.
- Request dropped before ack: protocol violation; transaction still completes and ack still pulses.
- Reset values: state IDLE, all acks 0, both strobes 0, mem_addr/mem_write_data/p0_rdata/p1_rdata 0, mem_sign_mask 0, grant 0, counter 0.
- rst mid-transaction: next cycle state is IDLE, strobes 0, no ack for the aborted access; a store already strobed may still be committed by memory; the requester must re-request.

## Timing
- Request first seen high during cycle 0 → ISSUE in cycle 1 → WAIT cycles 2..1+MEM_LAT → RESP/ack in cycle 2+MEM_LAT. With default MEM_LAT=2, ack in cycle 4.
- Each access occupies 3+MEM_LAT cycles including the IDLE sample cycle. Maximum throughput is one access per 5 cycles at default.
- A req still high in the cycle after ack is treated as a new request. Requesters must drop req on the edge ending the ack cycle unless issuing another access.
- No combinational path from any p*_ input to any mem_ output or ack.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last_grant register resets to 1 so port 0 wins first. On simultaneous requests, the port ≠ last_grant wins. last_grant updates when leaving IDLE.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. last_grant is not implemented.

## Test plan
- Reset, then p0 load, addr 0x1004, mask 4'b0010, memory returns 0xDEADBEEF → mem_memread pulses in cycle 1 only; p0_ack in cycle 4 with p0_rdata = 0xDEADBEEF; p1_ack stays 0.
- p1 store, addr 0x1008, wdata 0x000000A5, byte mask → mem_memwrite pulses once with mem_addr = 0x1008 and mem_write_data = 0x000000A5; p1_ack in cycle 4; p1_rdata unchanged.
- p0 and p1 requests held high continuously, with four accesses observed → fixed priority: grant 0,0,0,0; with DMEM_ARB_RR_EN: grant 0,1,0,1, acks every 5 cycles.
- MEM_LAT=5, p0 load → ack in cycle 7; data captured from mem_read_data in cycle 6.
- rst asserted in cycle 2 of a p0 load → strobes 0 and no ack through the following 10 cycles; state IDLE; fresh request then completes normally.
